// File: rtl/lc3b_pkg.sv
// Shared LC-3b datapath defaults, condition-code encodings and types.
package lc3b_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 8;

  typedef logic [2:0] cc_t;

  localparam cc_t CC_N = 3'b100;
  localparam cc_t CC_Z = 3'b010;
  localparam cc_t CC_P = 3'b001;

endpackage

// File: rtl/lc3b_cc_gen.sv
// Value-to-NZP encoder, shared by the register file and the branch unit.
module lc3b_cc_gen
  import lc3b_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] value,
  output cc_t               cc
);

  always_comb begin
    cc = CC_P;
    unique case (1'b1)
      value[DATA_W-1]: cc = CC_N;
      (value == '0):   cc = CC_Z;
      default:         cc = CC_P;
    endcase
  end

endmodule

// File: rtl/lc3b_regfile_sb.sv
// LC-3b register file with write-through bypass, NZP register and
// a pending-write scoreboard for decode-stage RAW detection.
module lc3b_regfile_sb
  import lc3b_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                NUM_REGS  = NUM_REGS_DEF,
  parameter int                ADDR_W    = 3,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   sr1,
  input  logic [ADDR_W-1:0]   sr2,
  output logic [DATA_W-1:0]   sr1_out,
  output logic [DATA_W-1:0]   sr2_out,
  input  logic                Write,
  input  logic [ADDR_W-1:0]   dr,
  input  logic [DATA_W-1:0]   dr_in,
  input  logic                ld_cc,
  output logic [2:0]          cc_out,
  input  logic                issue,
  input  logic [ADDR_W-1:0]   issue_dr,
  output logic                sr1_busy,
  output logic                sr2_busy,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  cc_t                 cc;
  cc_t                 cc_new;

  logic wr_ok;
  logic iss_ok;
  logic sr1_ok;
  logic sr2_ok;
  logic sr1_hit;
  logic sr2_hit;

  lc3b_cc_gen #(.DATA_W(DATA_W)) u_cc_gen (
    .value (dr_in),
    .cc    (cc_new)
  );

  assign wr_ok  = Write && (32'(dr) < NUM_REGS);
  assign iss_ok = issue && (32'(issue_dr) < NUM_REGS);
  assign sr1_ok = 32'(sr1) < NUM_REGS;
  assign sr2_ok = 32'(sr2) < NUM_REGS;

  assign sr1_hit = BYPASS && wr_ok && (dr == sr1);
  assign sr2_hit = BYPASS && wr_ok && (dr == sr2);

  always_comb begin
    sr1_out = '0;
    if (sr1_hit)     sr1_out = dr_in;
    else if (sr1_ok) sr1_out = regs[sr1];
  end

  always_comb begin
    sr2_out = '0;
    if (sr2_hit)     sr2_out = dr_in;
    else if (sr2_ok) sr2_out = regs[sr2];
  end

  assign sr1_busy = sr1_ok && busy[sr1] && !sr1_hit;
  assign sr2_busy = sr2_ok && busy[sr2] && !sr2_hit;

  // Set is applied after clear: a freshly issued producer outranks
  // the completing one on the same register.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[dr] = 1'b0;
    if (iss_ok) busy_nxt[issue_dr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      cc   <= CC_Z;
      busy <= '0;
    end else begin
      if (wr_ok)          regs[dr] <= dr_in;
      if (Write && ld_cc) cc <= cc_new;
      busy <= busy_nxt;
    end
  end

  assign cc_out   = cc;
  assign busy_vec = busy;

endmodule

// File: tb/tb_lc3b_regfile_sb.sv
// Directed scoreboard bench: bypassing (u_b) and non-bypassing (u_n)
// register files driven by the same stimulus.
module tb_lc3b_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sr1, sr2, dr, issue_dr;
  logic [15:0] dr_in;
  logic        Write, ld_cc, issue;

  logic [15:0] b_sr1_out, b_sr2_out, n_sr1_out, n_sr2_out;
  logic [2:0]  b_cc, n_cc;
  logic        b_sr1_busy, b_sr2_busy, n_sr1_busy, n_sr2_busy;
  logic [7:0]  b_busy, n_busy;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lc3b_regfile_sb #(.BYPASS(1'b1)) u_b (
    .clk(clk), .rst(rst), .sr1(sr1), .sr2(sr2),
    .sr1_out(b_sr1_out), .sr2_out(b_sr2_out),
    .Write(Write), .dr(dr), .dr_in(dr_in), .ld_cc(ld_cc),
    .cc_out(b_cc), .issue(issue), .issue_dr(issue_dr),
    .sr1_busy(b_sr1_busy), .sr2_busy(b_sr2_busy),
    .busy_vec(b_busy)
  );

  lc3b_regfile_sb #(.BYPASS(1'b0)) u_n (
    .clk(clk), .rst(rst), .sr1(sr1), .sr2(sr2),
    .sr1_out(n_sr1_out), .sr2_out(n_sr2_out),
    .Write(Write), .dr(dr), .dr_in(dr_in), .ld_cc(ld_cc),
    .cc_out(n_cc), .issue(issue), .issue_dr(issue_dr),
    .sr1_busy(n_sr1_busy), .sr2_busy(n_sr2_busy),
    .busy_vec(n_busy)
  );

  task automatic push(input string tag, input logic [15:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed %h expected none", obs);
    end else begin
      x = q.pop_front();
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Write = 0; ld_cc = 0; issue = 0;
    sr1 = 0; sr2 = 0; dr = 0; issue_dr = 0; dr_in = 0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      push($sformatf("rst_b_r%0d", i), 16'd0); check(b_sr1_out);
      push($sformatf("rst_n_r%0d", i), 16'd0); check(n_sr2_out);
    end
    push("rst_cc", 16'h2);       check(16'(b_cc));
    push("rst_busy", 16'h0);     check(16'(b_busy));
    push("rst_sr1_busy", 16'h0); check(16'(b_sr1_busy));

    // write then read
    Write = 1; dr = 7; dr_in = 16'd23; sr1 = 7;
    #1;
    push("byp_same", 16'd23);  check(b_sr1_out);
    push("nobyp_same", 16'd0); check(n_sr1_out);
    tick();
    Write = 0;
    #1;
    push("byp_next", 16'd23);   check(b_sr1_out);
    push("nobyp_next", 16'd23); check(n_sr1_out);

    // condition codes
    Write = 1; ld_cc = 1; dr = 1; dr_in = 16'h8000;
    tick();
    Write = 0; ld_cc = 0;
    push("cc_neg", 16'h4); check(16'(b_cc));
    Write = 1; ld_cc = 1; dr_in = 16'h0000;
    #1;
    push("cc_no_bypass", 16'h4); check(16'(b_cc));
    tick();
    Write = 0; ld_cc = 0;
    push("cc_zero", 16'h2); check(16'(n_cc));
    Write = 1; ld_cc = 1; dr_in = 16'h0001;
    tick();
    Write = 0; ld_cc = 0;
    push("cc_pos", 16'h1); check(16'(b_cc));
    Write = 1; ld_cc = 0; dr_in = 16'h8000;
    tick();
    Write = 0;
    push("cc_no_ld", 16'h1); check(16'(b_cc));
    ld_cc = 1;
    tick();
    ld_cc = 0;
    push("cc_ld_no_wr", 16'h1); check(16'(b_cc));

    // scoreboard set / clear
    issue = 1; issue_dr = 3;
    tick();
    issue = 0; sr1 = 3;
    #1;
    push("sb_vec_set", 16'h08);   check(16'(b_busy));
    push("sb_busy_b", 16'h1);     check(16'(b_sr1_busy));
    push("sb_busy_n", 16'h1);     check(16'(n_sr1_busy));
    Write = 1; dr = 3; dr_in = 16'h0005;
    #1;
    push("sb_wr_byp", 16'h0);     check(16'(b_sr1_busy));
    push("sb_wr_nobyp", 16'h1);   check(16'(n_sr1_busy));
    tick();
    Write = 0;
    push("sb_vec_clr", 16'h00);   check(16'(b_busy));
    push("sb_busy_clr", 16'h0);   check(16'(n_sr1_busy));

    // simultaneous issue and write on one index
    issue = 1; issue_dr = 5; Write = 1; dr = 5; dr_in = 16'h0042;
    tick();
    issue = 0; Write = 0;
    push("sim_set_wins", 16'h20); check(16'(b_busy));
    sr2 = 5;
    #1;
    push("sim_data", 16'h0042);   check(n_sr2_out);
    push("sim_sr2_busy", 16'h1);  check(16'(b_sr2_busy));

    // reset discards same-cycle write, issue and ld_cc
    rst = 1; Write = 1; ld_cc = 1; dr = 2; dr_in = 16'd9;
    issue = 1; issue_dr = 4;
    tick();
    rst = 0; Write = 0; ld_cc = 0; issue = 0; sr1 = 2; sr2 = 7;
    #1;
    push("mid_rst_r2", 16'd0);    check(b_sr1_out);
    push("mid_rst_r7", 16'd0);    check(n_sr2_out);
    push("mid_rst_busy", 16'h0);  check(16'(b_busy));
    push("mid_rst_cc", 16'h2);    check(16'(b_cc));

    if (q.size() != 0) begin
      errors++;
      $error("FAIL sb_leftover observed %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
